// File: rtl/serial_adder.sv
// Bit-serial add/subtract engine: one full-adder cell plus a carry flop, sequenced
// LSB-first over WIDTH clocks. Operands are loaded in parallel on start and the
// result is presented in parallel together with a one-cycle done pulse.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request, sampled only in idle
//   sub    0: A+B+Cin, 1: A-B (Cin ignored); sampled with start
//   A, B   operands, sampled with start
//   Cin    carry-in for add, sampled with start
//   busy   high while an operation is in flight (run or done)
//   done   one-cycle pulse, S/Cout/ovf updated on the same edge
//   S      result, holds the last completed value
//   Cout   carry out of the MSB (subtract: 1 = no borrow)
//   ovf    two's-complement overflow (carry into MSB xor carry out of MSB)

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   sh_s_q, sh_s_d;
    logic               carry_q, carry_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    // Full-adder cell on the current LSBs
    logic s_bit;
    logic carry_nxt;
    logic last_bit;

    assign s_bit     = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
    assign carry_nxt = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
    assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        sh_s_d  = sh_s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    sh_a_d  = A;
                    // Subtract as A + ~B + 1
                    sh_b_d  = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                sh_s_d  = {s_bit, sh_s_q[WIDTH-1:1]};
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    state_d = StDone;
                    s_d     = {s_bit, sh_s_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    // carry_q is the carry into the MSB while the MSB is processed
                    ovf_d   = carry_q ^ carry_nxt;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sh_s_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sh_s_q  <= sh_s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 instance plus an
// exhaustively exercised WIDTH=4 instance).

module tb_serial_adder;

    logic clk;
    logic rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] s4;

    int checks;
    int failures;
    int cyc;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .sub   (sub8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Cout  (cout8),
        .ovf   (ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .sub   (sub4),
        .A     (a4),
        .B     (b4),
        .Cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .S     (s4),
        .Cout  (cout4),
        .ovf   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse start for one cycle, then wait (bounded) for done.
    // lat = edges after the start edge until done is seen; busy_n = cycles with busy high.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sb, output int lat, output int busy_n);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        busy_n = busy8 ? 1 : 0;
        while (!done8 && lat < 50) begin
            @(negedge clk);
            lat++;
            if (busy8) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b S=%h Cout=%b ovf=%b, want all 0",
                     busy8, done8, s8, cout8, ovf8);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, done8, s8} !== 10'h000) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b S=%h, want 0 0 00", busy8, done8, s8);
        end
    endtask

    task automatic test_add_latency();
        int lat, bn;
        do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, lat, bn);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL add_latency: got %0d edges, want 8", lat);
        end
        checks++;
        if ({s8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_5a_3c: got S=%h Cout=%b ovf=%b, want S=96 Cout=0 ovf=1",
                     s8, cout8, ovf8);
        end
        @(negedge clk);
        checks++;
        if (bn !== 9 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL add_busy: got busy_cycles=%0d busy=%b done=%b, want 9 0 0",
                     bn, busy8, done8);
        end
    endtask

    task automatic test_carry();
        int lat, bn;
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bn);
        checks++;
        if ({s8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_ff_01: got S=%h Cout=%b ovf=%b, want S=00 Cout=1 ovf=0",
                     s8, cout8, ovf8);
        end
        do_op8(8'hFF, 8'h00, 1'b1, 1'b0, lat, bn);
        checks++;
        if ({s8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_ff_00_cin: got S=%h Cout=%b ovf=%b, want S=00 Cout=1 ovf=0",
                     s8, cout8, ovf8);
        end
    endtask

    task automatic test_sub();
        int lat, bn;
        do_op8(8'h10, 8'h20, 1'b1, 1'b1, lat, bn);
        checks++;
        if ({s8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sub_10_20: got S=%h Cout=%b ovf=%b, want S=f0 Cout=0 ovf=0",
                     s8, cout8, ovf8);
        end
        do_op8(8'h80, 8'h01, 1'b0, 1'b1, lat, bn);
        checks++;
        if ({s8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL sub_80_01: got S=%h Cout=%b ovf=%b, want S=7f Cout=1 ovf=1",
                     s8, cout8, ovf8);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        repeat (4) @(negedge clk);
        // Operand change mid-run: must not disturb op 1, is sampled by op 2
        a8 = 8'h40; b8 = 8'h05;
        n = 0;
        while (!done8 && n < 30) begin @(negedge clk); n++; end
        t1 = cyc;
        checks++;
        if (done8 !== 1'b1 || s8 !== 8'h33) begin
            failures++;
            $display("FAIL b2b_first: got done=%b S=%h, want 1 33", done8, s8);
        end
        repeat (3) @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; start8 = 1'b0;
        checks++;
        if (s8 !== 8'h33 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold: got S=%h busy=%b, want 33 1", s8, busy8);
        end
        n = 0;
        while (!done8 && n < 30) begin @(negedge clk); n++; end
        t2 = cyc;
        checks++;
        if (done8 !== 1'b1 || s8 !== 8'h45 || (t2 - t1) !== 10) begin
            failures++;
            $display("FAIL b2b_second: got done=%b S=%h period=%0d, want 1 45 10",
                     done8, s8, t2 - t1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || s8 !== 8'h45) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%b S=%h, want 0 45", busy8, s8);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn;
        logic saw_done;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);  // cnt has reached 4
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, s8, cout8, ovf8} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b S=%h Cout=%b ovf=%b, want all 0",
                     busy8, done8, s8, cout8, ovf8);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (done8 || busy8) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_abandon: got activity after reset=%b, want 0", saw_done);
        end
        do_op8(8'h01, 8'h01, 1'b0, 1'b0, lat, bn);
        checks++;
        if ({s8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0} || lat !== 8) begin
            failures++;
            $display("FAIL after_reset_op: got S=%h Cout=%b ovf=%b lat=%0d, want 02 0 0 8",
                     s8, cout8, ovf8, lat);
        end
    endtask

    task automatic test_exhaustive4();
        logic [4:0] full;
        logic [3:0] bx;
        logic       exp_ovf;
        int         n;
        for (int sb = 0; sb < 2; sb++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int a = 0; a < 16; a++) begin
                    for (int b = 0; b < 16; b++) begin
                        @(negedge clk);
                        a4 = 4'(a); b4 = 4'(b); cin4 = 1'(ci); sub4 = 1'(sb);
                        start4 = 1'b1;
                        @(negedge clk);
                        start4 = 1'b0;
                        n = 0;
                        while (!done4 && n < 20) begin @(negedge clk); n++; end
                        if (sb == 1) begin
                            bx   = ~4'(b);
                            full = {1'b0, 4'(a)} + {1'b0, bx} + 5'd1;
                        end else begin
                            bx   = 4'(b);
                            full = {1'b0, 4'(a)} + {1'b0, bx} + 5'(ci);
                        end
                        exp_ovf = (a4[3] == bx[3]) && (full[3] != a4[3]);
                        checks++;
                        if (done4 !== 1'b1 || {s4, cout4, ovf4} !== {full[3:0], full[4], exp_ovf})
                        begin
                            failures++;
                            $display("FAIL w4 sub=%0d cin=%0d a=%h b=%h: got done=%b S=%h C=%b V=%b, want 1 %h %b %b",
                                     sb, ci, a, b, done4, s4, cout4, ovf4,
                                     full[3:0], full[4], exp_ovf);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_add_latency();
        test_carry();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
